// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default operand width
   localparam int MUL_DEFAULT_WIDTH = 16;

   // Widest operand the magnitude helper can handle
   localparam int MUL_MAX_W = 64;

   // Two's-complement magnitude of the low w bits of v, result in the low w bits.
   // -2^(w-1) maps to 2^(w-1), which still fits in w unsigned bits.
   function automatic logic [MUL_MAX_W-1:0] mag_w(input logic [MUL_MAX_W-1:0] v,
                                                  input int w);
      logic [MUL_MAX_W-1:0] mask;
      mask = {MUL_MAX_W{1'b1}} >> (MUL_MAX_W - w);
      if (v[w-1])
         return ((~v) + MUL_MAX_W'(1)) & mask;
      else
         return v & mask;
   endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Controller FSM for seq_shift_add_mul: sequences load, iterate and result write.
module mul_ctrl
   import mul_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic eqz,
   output logic ldA,
   output logic ldB,
   output logic clrP,
   output logic ldP,
   output logic shift,
   output logic wr_prod,
   output logic busy,
   output logic done
);

   state_t r_state;
   state_t w_state_nxt;

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and control strobes; eqz means the next multiplier value is zero
   always_comb begin
      w_state_nxt = r_state;
      ldA         = 1'b0;
      ldB         = 1'b0;
      clrP        = 1'b0;
      ldP         = 1'b0;
      shift       = 1'b0;
      wr_prod     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               ldA  = 1'b1;
               ldB  = 1'b1;
               clrP = 1'b1;
               if (eqz) begin
                  wr_prod     = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         RUN: begin
            busy  = 1'b1;
            ldP   = 1'b1;
            shift = 1'b1;
            if (eqz) begin
               wr_prod     = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Radix-2 shift-and-add multiplier, signed or unsigned, with early termination
// once the remaining multiplier bits are zero. WIDTH may range from 2 to 32.
module seq_shift_add_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_DEFAULT_WIDTH
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    r_a;
   logic [WIDTH-1:0] r_b;
   logic [PW-1:0]    r_p;
   logic             r_neg;
   logic [PW-1:0]    r_product;

   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic             w_neg_in;
   logic [WIDTH-1:0] w_b_shift;
   logic [PW-1:0]    w_p_sum;
   logic [PW-1:0]    w_p_next;
   logic [PW-1:0]    w_prod_val;
   logic             w_eqz;
   logic             w_ldA, w_ldB, w_clrP, w_ldP, w_shift, w_wr_prod;

   // Operands are reduced to magnitudes up front; the sign is reapplied at the end
   assign w_mag_a  = signed_mode ? WIDTH'(mag_w(MUL_MAX_W'(a), WIDTH)) : a;
   assign w_mag_b  = signed_mode ? WIDTH'(mag_w(MUL_MAX_W'(b), WIDTH)) : b;
   assign w_neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

   assign w_b_shift = r_b >> 1;

   // On load the "next B" is the freshly latched |b|; during RUN it is B>>1
   assign w_eqz = w_ldB ? (w_mag_b == '0) : (w_b_shift == '0);

   assign w_p_sum    = r_b[0] ? (r_p + r_a) : r_p;
   assign w_p_next   = w_clrP ? '0 : w_p_sum;
   // Zero-multiplier shortcut has w_p_next = 0, so a stale r_neg is harmless there
   assign w_prod_val = r_neg ? (-w_p_next) : w_p_next;

   assign product = r_product;

   mul_ctrl u_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .eqz     (w_eqz),
      .ldA     (w_ldA),
      .ldB     (w_ldB),
      .clrP    (w_clrP),
      .ldP     (w_ldP),
      .shift   (w_shift),
      .wr_prod (w_wr_prod),
      .busy    (busy),
      .done    (done)
   );

   // Multiplicand/multiplier registers: load magnitudes, then shift each RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_neg <= 1'b0;
      end else begin
         if (w_ldA)
            r_a <= PW'(w_mag_a);
         else if (w_shift)
            r_a <= r_a << 1;
         if (w_ldB) begin
            r_b   <= w_mag_b;
            r_neg <= w_neg_in;
         end else if (w_shift) begin
            r_b <= w_b_shift;
         end
      end
   end

   // Accumulator: cleared on accept, conditionally adds A each RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_p <= '0;
      else if (w_clrP)
         r_p <= '0;
      else if (w_ldP)
         r_p <= w_p_sum;
   end

   // Result register: written only on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_product <= '0;
      else if (w_wr_prod)
         r_product <= w_prod_val;
   end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench for seq_shift_add_mul (WIDTH=16).
module tb_seq_shift_add_mul;

   typedef struct {
      logic [31:0] prod;
      int          start_cyc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int   cyc = 0;
   int   busy_cnt = 0;
   int   n_total = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   seq_shift_add_mul #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_prod(input logic [15:0] ta, input logic [15:0] tb,
                                            input bit sm);
      longint pa, pb;
      pa = sm ? longint'($signed(ta)) : longint'(ta);
      pb = sm ? longint'($signed(tb)) : longint'(tb);
      return 32'(pa * pb);
   endfunction

   function automatic int ref_lat(input logic [15:0] tb, input bit sm);
      logic [16:0] m;
      int k;
      m = (sm && tb[15]) ? (17'h10000 - {1'b0, tb}) : {1'b0, tb};
      k = 0;
      for (int i = 0; i < 17; i++)
         if (m[i]) k = i + 1;
      return k + 1;
   endfunction

   // Monitor: pop an expectation on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("spurious_done", 64'(done), 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("product", 64'(product), 64'(e.prod));
               chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
               chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic op(input logic [15:0] ta, input logic [15:0] tb, input bit sm,
                     input logic [31:0] ep, input int el, input bit poke);
      exp_t e;
      int   guard;
      @(negedge clk);
      a           = ta;
      b           = tb;
      signed_mode = sm;
      start       = 1'b1;
      e.prod      = ep;
      e.start_cyc = cyc;
      e.lat       = el;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a     = 16'hDEAD;
      b     = 16'hBEEF;
      if (poke) begin
         @(negedge clk);
         a           = 16'h0007;
         b           = 16'h0009;
         signed_mode = 1'b0;
         start       = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0) begin
         chk("done_timeout", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra, rb;
      bit          rs;

      // Reset held with start asserted
      rst_n = 1'b0;
      start = 1'b1;
      a     = 16'd3;
      b     = 16'd5;
      repeat (2) begin
         @(negedge clk);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
         chk("rst_product", 64'(product), 64'd0);
      end
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("rst_no_accept_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("rst_no_accept_busy2", 64'(busy), 64'd0);

      // Directed cases
      op(16'd3,    16'd5,    1'b0, 32'd15,        4,  1'b0);
      op(16'hFFFF, 16'h0000, 1'b0, 32'd0,         1,  1'b0);
      op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17,  1'b0);
      op(16'hFFFD, 16'd7,    1'b1, 32'hFFFFFFEB,  4,  1'b0);
      op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 17,  1'b0);
      op(16'd5,    16'hFFFF, 1'b1, 32'hFFFFFFFB,  2,  1'b0);
      op(16'hFFFF, 16'h0000, 1'b1, 32'd0,         1,  1'b0);

      // Start pulse during RUN is ignored
      op(16'd3,    16'h00FF, 1'b0, 32'h000002FD,  9,  1'b1);

      // Abort in RUN cycle C3 of a 16-iteration multiply
      @(negedge clk);
      a           = 16'd1;
      b           = 16'hFFFF;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", 64'(product), 64'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_idle_busy", 64'(busy), 64'd0);

      // Operation right after abort
      op(16'h1234, 16'h0010, 1'b0, 32'h00012340, 6, 1'b0);

      // Randomised operands against the reference model
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         rs = 1'($urandom);
         op(ra, rb, rs, ref_prod(ra, rb, rs), ref_lat(rb, rs), 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_shift_add_mul.md
# seq_shift_add_mul

Parametrised sequential multiplier with an integrated controller and a start/done handshake. It multiplies two WIDTH-bit operands over several clock cycles using radix-2 shift-and-add, and supports both signed and unsigned operation. It terminates early once the remaining multiplier bits are zero. It is the successor to the 16-bit repeated-addition multiplier datapath and its external controller, and sits behind any register-level client that needs a low-area multiply.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (≥2); the product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 treats a and b as two's-complement; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2*WIDTH  result; held until the next accepted start.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**, when start=1:
  - Latch |a| into the A register (2*WIDTH bits, zero-extended) and |b| into the B register (WIDTH bits).
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]) and clear the accumulator P.
  - Magnitudes are computed only when signed_mode=1; otherwise the raw values are used.
  - Go to DONE if |b|==0 (product ← 0), else go to RUN.
- **RUN**, each cycle:
  - If B[0]=1, P ← P + A (2*WIDTH-bit add, no carry-out possible).
  - A ← A<<1; B ← B>>1.
  - Exit when the next B is zero (the eqz condition). Then go to DONE and write product ← neg ? −(P_next) : P_next.
- **DONE**: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, with no queuing. Operand changes after acceptance have no effect.
- The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits in WIDTH unsigned bits. The signed product range is [−2^(2W−2)+2^(W−1), 2^(2W−2)], which fits exactly in 2*WIDTH bits with no overflow.
- Unsigned mode is exact for all inputs.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0. A, B, P and neg are cleared.
- rst_n low in any state, including mid-RUN, aborts the operation on that edge. No done is produced for the aborted operation.
- Iteration count: k = index of the highest set bit of |b|, plus 1 (1…WIDTH). k = 0 when |b|=0.
- Latency: start is high in cycle C0, RUN occupies C1…Ck, and done is high in C(k+1). Latency is therefore k+1 cycles, with a minimum of 1 (b=0) and a maximum of WIDTH+1.
- Throughput: the earliest next accepted start is the cycle after done, so back-to-back operations cost k+2 cycles each.
- busy rises in C1 and falls in the cycle after done.
- product changes only on the edge that enters DONE.

## Structure
- Package mul_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - a function for WIDTH-bit two's-complement magnitude.
- The controller is one sub-module, mul_ctrl:
  - It holds the FSM.
  - Its inputs are start and eqz (B_next==0).
  - Its outputs are ldA, ldB, clrP, ldP, shift and wr_prod.
- The registers and adder stay in the top module seq_shift_add_mul.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, product=0, and no operation is accepted.
- Unsigned: WIDTH=16, a=3, b=5 → done 4 cycles after start (k=3), product=15, busy high for 4 cycles.
- Zero and maximum:
  - b=0, a=0xFFFF → done in C1, product=0.
  - a=b=0xFFFF unsigned → done in C17, product=0xFFFE0001.
- Signed, signed_mode=1:
  - a=0xFFFD (−3), b=7 → product=0xFFFFFFEB (−21), latency 4.
  - a=b=0x8000 → product=0x40000000, latency 17.
  - a=5, b=0xFFFF (−1) → product=0xFFFFFFFB, latency 2.
- Handshake and abort:
  - A start pulse during RUN with new operands is ignored, and the first result is unchanged.
  - rst_n=0 in RUN cycle C3 of a 16-iteration multiply → IDLE next cycle, product=0, no done pulse.
  - A new start immediately after the abort is accepted normally.
